// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
// ALU codes, FSM states, opcode/funct values and instruction classes.
package mc_ctrl_pkg;

  localparam logic [2:0] A_NOP = 3'd0;
  localparam logic [2:0] A_ADD = 3'd1;
  localparam logic [2:0] A_SUB = 3'd2;
  localparam logic [2:0] A_AND = 3'd3;
  localparam logic [2:0] A_OR  = 3'd4;
  localparam logic [2:0] A_XOR = 3'd5;
  localparam logic [2:0] A_NOR = 3'd6;
  localparam logic [2:0] A_SLT = 3'd7;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EX_R,
    S_EX_I,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_I,
    S_WB_LW,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_R,
    C_ALUI,
    C_LW,
    C_SW,
    C_BEQ,
    C_BNE,
    C_J,
    C_ILL
  } iclass_e;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  function automatic iclass_e classify(input logic [5:0] op);
    iclass_e c;
    case (op)
      OP_R:      c = C_R;
      OP_ADDI,
      OP_ADDIU,
      OP_SLTI,
      OP_ANDI,
      OP_ORI,
      OP_XORI:   c = C_ALUI;
      OP_LW:     c = C_LW;
      OP_SW:     c = C_SW;
      OP_BEQ:    c = C_BEQ;
      OP_BNE:    c = C_BNE;
      OP_J:      c = C_J;
      default:   c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_alu_op_decode.sv
// Combinational ALU-op decoder: class/funct/opcode to alu_op.
// Also reused by pipeline control, so it carries its own valid flag.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  iclass_e    cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       imm_zext,
  output logic       valid
);

  always_comb begin
    alu_op   = A_NOP;
    imm_zext = 1'b0;
    valid    = 1'b1;
    case (cls)
      C_R: begin
        case (funct)
          F_ADD, F_ADDU: alu_op = A_ADD;
          F_SUB, F_SUBU: alu_op = A_SUB;
          F_AND:         alu_op = A_AND;
          F_OR:          alu_op = A_OR;
          F_XOR:         alu_op = A_XOR;
          F_NOR:         alu_op = A_NOR;
          F_SLT:         alu_op = A_SLT;
          F_SLL:         alu_op = A_NOP;
          default:       valid  = 1'b0;
        endcase
      end
      C_ALUI: begin
        case (opcode)
          OP_ADDI, OP_ADDIU: alu_op = A_ADD;
          OP_SLTI:           alu_op = A_SLT;
          OP_ANDI: begin
            alu_op   = A_AND;
            imm_zext = 1'b1;
          end
          OP_ORI: begin
            alu_op   = A_OR;
            imm_zext = 1'b1;
          end
          OP_XORI: begin
            alu_op   = A_XOR;
            imm_zext = 1'b1;
          end
          default: valid = 1'b0;
        endcase
      end
      C_LW, C_SW:   alu_op = A_ADD;
      C_BEQ, C_BNE: alu_op = A_SUB;
      C_J:          alu_op = A_NOP;
      default:      valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle MIPS control FSM: Moore outputs decoded from state,
// with mem_ready qualifying the fetch strobes.
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
#(
  parameter int PC_STEP     = 4,
  parameter bit TRAP_STICKY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        branch_ne,
  output logic [1:0]  pc_source,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        imm_zext,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [31:0] instr_retired
);

  state_e      state_q;
  iclass_e     cls_q;
  iclass_e     cls_n;
  logic [31:0] cnt_q;
  logic [2:0]  dec_op;
  logic        dec_zext;
  logic        dec_ok;
  logic        retire;

  // Branch resolution and the PC step live in the datapath.
  logic [32:0] unused_bits;
  assign unused_bits = {alu_zero, 32'(PC_STEP)};

  assign cls_n         = classify(opcode);
  assign instr_retired = cnt_q;

  alu_op_decode u_dec (
    .cls      (cls_q),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_op),
    .imm_zext (dec_zext),
    .valid    (dec_ok)
  );

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_WB_R, S_WB_I, S_WB_LW,
      S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR:         retire = mem_ready;
      default:          retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cls_q   <= C_ILL;
      cnt_q   <= '0;
    end else begin
      if (retire) cnt_q <= cnt_q + 32'd1;
      case (state_q)
        S_FETCH:
          if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          cls_q <= cls_n;
          case (cls_n)
            C_R:          state_q <= S_EX_R;
            C_ALUI:       state_q <= S_EX_I;
            C_LW, C_SW:   state_q <= S_ADDR;
            C_BEQ, C_BNE: state_q <= S_BRANCH;
            C_J:          state_q <= S_JUMP;
            default:      state_q <= S_TRAP;
          endcase
        end
        S_EX_R:
          state_q <= dec_ok ? S_WB_R : S_TRAP;
        S_EX_I:
          state_q <= S_WB_I;
        S_ADDR:
          state_q <= (cls_q == C_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:
          if (mem_ready) state_q <= S_WB_LW;
        S_MEM_WR:
          if (mem_ready) state_q <= S_FETCH;
        S_TRAP:
          if (!TRAP_STICKY) state_q <= S_FETCH;
        default:
          state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    alu_op        = A_NOP;
    illegal       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = A_ADD;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_op    = A_ADD;
        end
        S_EX_R: begin
          alu_src_a = 1'b1;
          alu_op    = dec_op;
        end
        S_EX_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = dec_op;
          imm_zext  = dec_zext;
        end
        S_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = A_ADD;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_WB_R: begin
          reg_write = (funct != F_SLL);
          reg_dst   = 1'b1;
        end
        S_WB_I:
          reg_write = 1'b1;
        S_WB_LW: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = A_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          branch_ne     = (cls_q == C_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_TRAP:
          illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Self-checking bench for mc_ctrl_unit against a per-instruction
// cycle-plan model built from the instruction set's control rules.
module tb_mc_ctrl_unit;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [2:0] alu_op;
    logic       illegal;
  } ctl_t;

  typedef struct {
    ctl_t  c;
    bit    wait_mem;
    bit    is_fetch;
    string tag;
  } step_t;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, SUB = 3'd2, AND_ = 3'd3;
  localparam logic [2:0] OR_ = 3'd4, XOR_ = 3'd5, NOR_ = 3'd6, SLT = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, branch_ne, ir_write, i_or_d;
  logic        mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
  logic        alu_src_a, imm_zext, illegal;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_op;
  logic [31:0] instr_retired;
  ctl_t        obs;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = '0;
  step_t       plan[$];

  always #5 clk = ~clk;

  mc_ctrl_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .imm_zext      (imm_zext),
    .alu_op        (alu_op),
    .illegal       (illegal),
    .instr_retired (instr_retired)
  );

  assign obs = {pc_write, pc_write_cond, branch_ne, pc_source, ir_write,
                i_or_d, mem_read, mem_write, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op,
                illegal};

  // {valid, code} for R-type funct values
  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return {1'b1, ADD};
      6'h22, 6'h23: return {1'b1, SUB};
      6'h24:        return {1'b1, AND_};
      6'h25:        return {1'b1, OR_};
      6'h26:        return {1'b1, XOR_};
      6'h27:        return {1'b1, NOR_};
      6'h2A:        return {1'b1, SLT};
      6'h00:        return {1'b1, NOP};
      default:      return {1'b0, NOP};
    endcase
  endfunction

  // {valid, zext, code} for immediate ALU opcodes
  function automatic logic [4:0] i_alu(input logic [5:0] op);
    case (op)
      6'h08, 6'h09: return {2'b10, ADD};
      6'h0A:        return {2'b10, SLT};
      6'h0C:        return {2'b11, AND_};
      6'h0D:        return {2'b11, OR_};
      6'h0E:        return {2'b11, XOR_};
      default:      return {2'b00, NOP};
    endcase
  endfunction

  function automatic void add_step(input ctl_t c, input bit w,
                                   input bit f, input string t);
    step_t s;
    s.c = c;
    s.wait_mem = w;
    s.is_fetch = f;
    s.tag = t;
    plan.push_back(s);
  endfunction

  function automatic void build(input logic [5:0] op,
                                input logic [5:0] fn,
                                output bit legal);
    ctl_t c;
    logic [3:0] r;
    logic [4:0] im;
    plan.delete();
    legal = 1'b1;
    c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_op = ADD;
    c.pc_write = 1; c.ir_write = 1;
    add_step(c, 1, 1, "fetch");
    c = '0; c.alu_src_b = 2'b11; c.alu_op = ADD;
    add_step(c, 0, 0, "decode");
    im = i_alu(op);
    if (op == 6'h00) begin
      r = r_alu(fn);
      c = '0; c.alu_src_a = 1; c.alu_op = r[2:0];
      add_step(c, 0, 0, "ex_r");
      if (r[3]) begin
        c = '0; c.reg_write = (fn != 6'h00); c.reg_dst = 1;
        add_step(c, 0, 0, "wb_r");
      end else legal = 1'b0;
    end else if (im[4]) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
      c.alu_op = im[2:0]; c.imm_zext = im[3];
      add_step(c, 0, 0, "ex_i");
      c = '0; c.reg_write = 1;
      add_step(c, 0, 0, "wb_i");
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_op = ADD;
      add_step(c, 0, 0, "addr");
      if (op == 6'h23) begin
        c = '0; c.mem_read = 1; c.i_or_d = 1;
        add_step(c, 1, 0, "mem_rd");
        c = '0; c.reg_write = 1; c.mem_to_reg = 1;
        add_step(c, 0, 0, "wb_lw");
      end else begin
        c = '0; c.mem_write = 1; c.i_or_d = 1;
        add_step(c, 1, 0, "mem_wr");
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = '0; c.alu_src_a = 1; c.alu_op = SUB; c.pc_write_cond = 1;
      c.pc_source = 2'b01; c.branch_ne = (op == 6'h05);
      add_step(c, 0, 0, "branch");
    end else if (op == 6'h02) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'b10;
      add_step(c, 0, 0, "jump");
    end else legal = 1'b0;
  endfunction

  task automatic chk_ctl(input string tag, input ctl_t e);
    alu_zero = 1'($urandom);
    @(negedge clk);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s op=%h fn=%h obs=%h exp=%h", tag, opcode, funct,
             obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] e);
    checks++;
    assert (instr_retired === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, instr_retired, e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    chk_ctl("in_reset", '0);
    rst_n = 1'b1;
    model_cnt = '0;
    chk_cnt("reset_cnt", model_cnt);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fst, input int mst);
    bit   legal;
    int   n;
    ctl_t e;
    build(op, fn, legal);
    opcode = op;
    funct = fn;
    foreach (plan[i]) begin
      if (plan[i].wait_mem) begin
        n = plan[i].is_fetch ? fst : mst;
        if (n < 0) n = int'($urandom_range(0, 2));
        e = plan[i].c;
        if (plan[i].is_fetch) begin
          e.pc_write = 0;
          e.ir_write = 0;
        end
        repeat (n) begin
          mem_ready = 1'b0;
          chk_ctl({plan[i].tag, "_stall"}, e);
        end
        mem_ready = 1'b1;
      end else mem_ready = 1'($urandom);
      chk_ctl(plan[i].tag, plan[i].c);
    end
    if (legal) begin
      model_cnt = model_cnt + 32'd1;
      chk_cnt("retired", model_cnt);
    end else begin
      e = '0;
      e.illegal = 1'b1;
      repeat (10) begin
        mem_ready = 1'($urandom);
        chk_ctl("trap", e);
      end
      chk_cnt("trap_cnt", model_cnt);
    end
  endtask

  logic [5:0] r_fn[10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                           6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};
  logic [5:0] ops[11]  = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                           6'h0E, 6'h23, 6'h2B, 6'h04, 6'h05};

  initial begin
    ctl_t fe;
    bit   lg;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(6'h00, 6'h20, 0, 0);
    run_instr(6'h23, 6'h00, 0, 2);
    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0);
    run_instr(6'h0E, 6'h11, 0, 0);
    run_instr(6'h0A, 6'h00, 0, 0);
    run_instr(6'h02, 6'h00, 1, 0);
    run_instr(6'h2B, 6'h00, 0, 1);
    run_instr(6'h00, 6'h00, 0, 0);

    for (int k = 0; k < 60; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 5) == 0) ? 6'h02 :
           ops[$urandom_range(0, 10)];
      run_instr(op, (op == 6'h00) ? r_fn[$urandom_range(0, 9)]
                                  : 6'($urandom), -1, -1);
    end

    // reset while a store is stalled in its memory phase
    build(6'h2B, 6'h00, lg);
    opcode = 6'h2B;
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      chk_ctl(plan[i].tag, plan[i].c);
    end
    mem_ready = 1'b0;
    chk_ctl("mem_wr_stall", plan[3].c);
    do_reset();
    fe = plan[0].c;
    mem_ready = 1'b0;
    fe.pc_write = 0;
    fe.ir_write = 0;
    chk_ctl("fetch_after_rst", fe);

    // counter wrap from a preset all-ones value
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    model_cnt = 32'hFFFF_FFFF;
    chk_cnt("preset", model_cnt);
    run_instr(6'h02, 6'h00, 0, 0);
    chk_cnt("wrapped", 32'h0);

    run_instr(6'h00, 6'h3F, 0, 0);
    do_reset();
    run_instr(6'h3F, 6'h00, 0, 0);
    do_reset();
    mem_ready = 1'b1;
    chk_ctl("fetch_clear", plan[0].c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
